// File: rtl/pipelined_fetch_unit_if.sv
// Fetch-unit bus: decode-side controls in, fetch address and status out.
// master = decode/control side, slave = fetch unit.
interface pipelined_fetch_unit_if #(
  parameter int PC_W  = 8,
  parameter int CYC_W = 17
);
  logic             init_ctrl;
  logic             stall;
  logic             branch_ctrl;
  logic             jump_ctrl;
  logic             call_ctrl;
  logic             ret_ctrl;
  logic             done_ctrl;
  logic [PC_W-1:0]  jump_val;
  logic [PC_W-1:0]  branch_val;
  logic [PC_W-1:0]  instruction_number;
  logic             instr_valid;
  logic             halted;
  logic [CYC_W-1:0] cycle_counter;
  logic             ras_err;

  modport master (
    output init_ctrl, stall, branch_ctrl, jump_ctrl,
    output call_ctrl, ret_ctrl, done_ctrl,
    output jump_val, branch_val,
    input  instruction_number, instr_valid,
    input  halted, cycle_counter, ras_err
  );

  modport slave (
    input  init_ctrl, stall, branch_ctrl, jump_ctrl,
    input  call_ctrl, ret_ctrl, done_ctrl,
    input  jump_val, branch_val,
    output instruction_number, instr_valid,
    output halted, cycle_counter, ras_err
  );
endinterface

// File: rtl/pipelined_fetch_unit.sv
// PC / fetch sequencer with stall, branch, halt and saturating cycle count.
// Define FETCH_RAS_EN to add a hardware return-address stack.
module pipelined_fetch_unit #(
  parameter int PC_W      = 8,
  parameter int CYC_W     = 17,
  parameter int RAS_DEPTH = 4
) (
  input logic                   clock,
  input logic                   reset,
  pipelined_fetch_unit_if.slave bus
);
  typedef enum logic {RUN, HALT} state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  inum_q, inum_d;
  logic [PC_W-1:0]  pc_inc;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

`ifdef FETCH_RAS_EN
  localparam int AW   = $clog2(RAS_DEPTH);
  localparam int SP_W = AW + 1;

  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic [AW-1:0]   rd_idx, wr_idx;
  logic            err_q, err_d;
  logic            push;
  logic            full;

  assign rd_idx = AW'(sp_q - 1'b1);
  assign wr_idx = AW'(sp_q);
  assign full   = (sp_q == SP_W'(RAS_DEPTH));
`endif

  assign pc_inc = pc_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inum_d   = inum_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cyc_d    = cyc_q;
`ifdef FETCH_RAS_EN
    sp_d     = sp_q;
    err_d    = err_q;
    push     = 1'b0;
`endif
    // Every RUN cycle counts, stalled or not; HALT freezes it.
    if (state_q == RUN && cyc_q != '1)
      cyc_d = cyc_q + 1'b1;

    if (bus.init_ctrl) begin
      state_d  = RUN;
      pc_d     = '0;
      valid_d  = 1'b0;
      halted_d = 1'b0;
`ifdef FETCH_RAS_EN
      sp_d     = '0;
`endif
    end else if (state_q == RUN) begin
      if (bus.done_ctrl) begin
        state_d  = HALT;
        halted_d = 1'b1;
        valid_d  = 1'b0;
      end else if (bus.stall) begin
        valid_d = 1'b0;
      end else begin
        inum_d  = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_inc;
        // Same-width add is the sign-extended add mod 2^PC_W.
        if (bus.branch_ctrl)
          pc_d = pc_q + bus.branch_val;
`ifdef FETCH_RAS_EN
        else if (bus.ret_ctrl) begin
          if (sp_q != '0) begin
            pc_d = ras_q[rd_idx];
            sp_d = sp_q - 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.call_ctrl) begin
          pc_d = bus.jump_val;
          if (full) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
            sp_d = sp_q + 1'b1;
          end
        end
`else
        else if (bus.ret_ctrl)
          pc_d = pc_inc;
        else if (bus.call_ctrl)
          pc_d = bus.jump_val;
`endif
        else if (bus.jump_ctrl)
          pc_d = bus.jump_val;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= '0;
      inum_q   <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inum_q   <= inum_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cyc_q    <= cyc_d;
    end
  end

`ifdef FETCH_RAS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Entry storage needs no reset; sp_q alone defines validity.
  always_ff @(posedge clock) begin
    if (push)
      ras_q[wr_idx] <= pc_inc;
  end

  assign bus.ras_err = err_q;
`else
  assign bus.ras_err = 1'b0;
`endif

  assign bus.instruction_number = inum_q;
  assign bus.instr_valid        = valid_q;
  assign bus.halted             = halted_q;
  assign bus.cycle_counter      = cyc_q;
endmodule

// File: tb/tb_pipelined_fetch_unit.sv
// Directed bench for pipelined_fetch_unit: default DUT plus a CYC_W=4
// instance for counter saturation and asynchronous reset.
module tb_pipelined_fetch_unit;
  logic clock;
  logic reset;
  logic rst_s;

  int n_vec = 0;
  int n_err = 0;

  pipelined_fetch_unit_if #(.PC_W(8), .CYC_W(17)) bus ();
  pipelined_fetch_unit_if #(.PC_W(8), .CYC_W(4))  sbus ();

  pipelined_fetch_unit #(
    .PC_W(8), .CYC_W(17), .RAS_DEPTH(4)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  pipelined_fetch_unit #(
    .PC_W(8), .CYC_W(4), .RAS_DEPTH(4)
  ) u_sat (
    .clock (clock),
    .reset (rst_s),
    .bus   (sbus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clr();
    bus.init_ctrl   = 1'b0;
    bus.stall       = 1'b0;
    bus.branch_ctrl = 1'b0;
    bus.jump_ctrl   = 1'b0;
    bus.call_ctrl   = 1'b0;
    bus.ret_ctrl    = 1'b0;
    bus.done_ctrl   = 1'b0;
    bus.jump_val    = '0;
    bus.branch_val  = '0;
  endtask

  initial begin
    clr();
    sbus.init_ctrl   = 1'b0;
    sbus.stall       = 1'b0;
    sbus.branch_ctrl = 1'b0;
    sbus.jump_ctrl   = 1'b0;
    sbus.call_ctrl   = 1'b0;
    sbus.ret_ctrl    = 1'b0;
    sbus.done_ctrl   = 1'b0;
    sbus.jump_val    = '0;
    sbus.branch_val  = '0;
    reset = 1'b0;
    rst_s = 1'b0;
    #1;
    reset = 1'b1;
    rst_s = 1'b1;
    #1;
    chk("rst_inum",  32'(bus.instruction_number), 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_halt",  32'(bus.halted), 0);
    chk("rst_cyc",   32'(bus.cycle_counter), 0);
    chk("rst_err",   32'(bus.ras_err), 0);
    step(2);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step();
      chk("seq_inum",  32'(bus.instruction_number), 32'(i));
      chk("seq_valid", 32'(bus.instr_valid), 1);
    end
    chk("seq_cyc", 32'(bus.cycle_counter), 5);

    bus.jump_ctrl = 1'b1;
    bus.jump_val  = 8'd250;
    step();
    clr();
    bus.branch_ctrl = 1'b1;
    bus.branch_val  = 8'hFC;
    step();
    chk("jmp_250", 32'(bus.instruction_number), 250);
    clr();
    step();
    chk("br_neg4", 32'(bus.instruction_number), 246);
    chk("br_cyc",  32'(bus.cycle_counter), 8);

    bus.jump_ctrl = 1'b1;
    bus.jump_val  = 8'd255;
    step();
    clr();
    step();
    chk("pc_255", 32'(bus.instruction_number), 255);
    step();
    chk("wrap_0", 32'(bus.instruction_number), 0);

    bus.jump_ctrl = 1'b1;
    bus.jump_val  = 8'd7;
    step();
    chk("pre_stall", 32'(bus.instruction_number), 1);
    chk("pre_cyc",   32'(bus.cycle_counter), 12);
    bus.stall    = 1'b1;
    bus.jump_val = 8'd99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_inum",  32'(bus.instruction_number), 1);
      chk("stl_valid", 32'(bus.instr_valid), 0);
    end
    chk("stl_cyc", 32'(bus.cycle_counter), 15);
    clr();
    step();
    chk("rel_inum",  32'(bus.instruction_number), 7);
    chk("rel_valid", 32'(bus.instr_valid), 1);

    step(4);
    chk("pre_done_cyc",  32'(bus.cycle_counter), 20);
    chk("pre_done_inum", 32'(bus.instruction_number), 11);
    bus.done_ctrl = 1'b1;
    step();
    chk("done_halt",  32'(bus.halted), 1);
    chk("done_valid", 32'(bus.instr_valid), 0);
    chk("done_cyc",   32'(bus.cycle_counter), 21);
    clr();
    bus.jump_ctrl   = 1'b1;
    bus.jump_val    = 8'd77;
    bus.branch_ctrl = 1'b1;
    bus.branch_val  = 8'd3;
    step(10);
    chk("halt_cyc",   32'(bus.cycle_counter), 21);
    chk("halt_halt",  32'(bus.halted), 1);
    chk("halt_inum",  32'(bus.instruction_number), 11);
    chk("halt_valid", 32'(bus.instr_valid), 0);
    clr();
    bus.init_ctrl = 1'b1;
    step();
    chk("init_halt",  32'(bus.halted), 0);
    chk("init_valid", 32'(bus.instr_valid), 0);
    chk("init_cyc",   32'(bus.cycle_counter), 21);
    clr();
    step();
    chk("init_inum",  32'(bus.instruction_number), 0);
    chk("init_vld1",  32'(bus.instr_valid), 1);
    chk("resume_cyc", 32'(bus.cycle_counter), 22);

`ifdef FETCH_RAS_EN
    bus.jump_ctrl = 1'b1;
    bus.jump_val  = 8'd10;
    step();
    clr();
    for (int i = 2; i <= 6; i++) begin
      bus.call_ctrl = 1'b1;
      bus.jump_val  = 8'(i * 10);
      step();
      chk("call_inum", 32'(bus.instruction_number), 32'((i - 1) * 10));
    end
    chk("ovf_err", 32'(bus.ras_err), 1);
    clr();
    bus.ret_ctrl = 1'b1;
    step();
    chk("ret_from", 32'(bus.instruction_number), 60);
    for (int i = 4; i >= 1; i--) begin
      step();
      chk("ret_inum", 32'(bus.instruction_number), 32'(i * 10 + 1));
    end
    clr();
    step();
    chk("unf_inum", 32'(bus.instruction_number), 12);
    chk("unf_err",  32'(bus.ras_err), 1);
`else
    bus.call_ctrl = 1'b1;
    bus.jump_val  = 8'd40;
    step();
    clr();
    bus.ret_ctrl = 1'b1;
    step();
    chk("call_jmp", 32'(bus.instruction_number), 40);
    step();
    chk("ret_ign", 32'(bus.instruction_number), 41);
    clr();
    step();
    chk("ret_seq", 32'(bus.instruction_number), 42);
    chk("no_err",  32'(bus.ras_err), 0);
`endif

    rst_s = 1'b0;
    step(20);
    chk("sat_cyc",   32'(sbus.cycle_counter), 15);
    chk("sat_inum",  32'(sbus.instruction_number), 19);
    chk("sat_valid", 32'(sbus.instr_valid), 1);
    sbus.stall = 1'b1;
    step(2);
    chk("sat_stl",   32'(sbus.instr_valid), 0);
    chk("sat_hold",  32'(sbus.instruction_number), 19);
    #2;
    rst_s = 1'b1;
    #1;
    chk("ar_inum",  32'(sbus.instruction_number), 0);
    chk("ar_valid", 32'(sbus.instr_valid), 0);
    chk("ar_halt",  32'(sbus.halted), 0);
    chk("ar_cyc",   32'(sbus.cycle_counter), 0);
    chk("ar_err",   32'(sbus.ras_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipelined_fetch_unit.md
# pipelined_fetch_unit

- Parametrised program-counter and fetch sequencer for the lab CPU; drives `instruction_number` into instruction memory and reports a cycle count for benchmarking.
- Adds the following over the 8-bit fixed sequencer:
  - configurable PC and counter widths
  - a stall handshake from the decode stage
  - signed relative branches
  - a synthesizable halt state
  - a saturating cycle counter
  - an optional hardware return-address stack for call/return.

## Interface
Parameters:
- `PC_W`, 8: program counter / instruction address width.
- `CYC_W`, 17: cycle counter width.
- `RAS_DEPTH`, 4: return-address stack entries (power of two, ≥2; used only with `FETCH_RAS_EN`).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `init_ctrl` in 1: synchronous restart, PC ← 0.
- `stall` in 1: decode stage not ready; hold fetch.
- `branch_ctrl` in 1: relative branch.
- `jump_ctrl` in 1: absolute jump.
- `call_ctrl` in 1: call; target `jump_val`.
- `ret_ctrl` in 1: return to top of stack.
- `done_ctrl` in 1: program finished; enter HALT.
- `jump_val` in `PC_W`: absolute target.
- `branch_val` in `PC_W`: two's-complement signed offset.
- `instruction_number` out `PC_W`: registered fetch address.
- `instr_valid` out 1: `instruction_number` is a new fetch this cycle.
- `halted` out 1: unit is in HALT.
- `cycle_counter` out `CYC_W`: cycles spent in RUN, saturating.
- `ras_err` out 1: sticky; stack overflow or underflow seen.

## Operation
- Two states:
  - RUN: entered from reset, or from HALT via `init_ctrl`.
  - HALT: entered from RUN when `done_ctrl` = 1.
- Priority per RUN cycle:
  1. `init_ctrl`
  2. `done_ctrl`
  3. `stall`
  4. `branch_ctrl`
  5. `ret_ctrl`
  6. `call_ctrl`
  7. `jump_ctrl`
  8. sequential
- Non-stalled RUN cycle:
  - `instruction_number` ← pc, `instr_valid` ← 1.
  - pc ← next, chosen as:
    - branch: pc + sign-extended `branch_val`, mod 2^`PC_W`.
    - ret: pop.
    - call: `jump_val`, pushing pc+1.
    - jump: `jump_val`.
    - sequential: pc+1, wrapping at 2^`PC_W`−1 → 0.
- Stalled cycle:
  - pc and `instruction_number` hold; `instr_valid` ← 0.
  - branch/jump/call/ret are ignored (the decode stage re-presents them).
- `init_ctrl`, in any state and overriding `stall`:
  - pc ← 0, `instr_valid` ← 0, state ← RUN, stack emptied.
  - `cycle_counter` and `ras_err` are kept.
- `done_ctrl` in RUN:
  - state ← HALT, `halted` ← 1, `instr_valid` ← 0; pc frozen.
  - In HALT all inputs except `init_ctrl` and `reset` are ignored.
- `cycle_counter`:
  - Increments on every RUN cycle, including stalled cycles and the `done_ctrl` cycle.
  - Frozen in HALT; sticks at all-ones and never wraps.
  - Cleared only by `reset`.

## Timing
- Reset values: pc=0, `instruction_number`=0, `instr_valid`=0, `halted`=0, `cycle_counter`=0, `ras_err`=0, stack empty, state RUN.
- First fetch of address 0 appears on `instruction_number` one edge after `reset` deasserts, with `instr_valid`=1.
- Control inputs are sampled at the edge. The redirect takes effect on the next issued fetch, one cycle after sampling.
- Outputs are registered; `cycle_counter` is a direct register output.
- `reset` asserted mid-operation, including in HALT or mid-stall, forces reset values immediately and asynchronously.

## Configuration
- `FETCH_RAS_EN` defined:
  - `RAS_DEPTH`-entry LIFO is instantiated.
  - Call on a full stack: jump still taken, push dropped, `ras_err` ← 1.
  - Ret on an empty stack: pc ← pc+1, `ras_err` ← 1.
  - Call and ret in the same cycle: ret wins, no push.
- `FETCH_RAS_EN` undefined:
  - No stack storage.
  - `call_ctrl` behaves as `jump_ctrl`; `ret_ctrl` is ignored (sequential).
  - `ras_err` tied 0.

## Test plan
- Reset, then 5 free-running cycles → `instruction_number` 0,1,2,3,4 with `instr_valid`=1; `cycle_counter`=5.
- `PC_W`=8, pc=250, `branch_ctrl`=1, `branch_val`=8'hFC (−4) → next fetch 246. From pc=255 sequential → 0.
- `stall`=1 for 3 cycles at pc=7 with `jump_ctrl`=1 → `instruction_number` holds, `instr_valid`=0, no jump, counter +3. Release → fetch 7.
- `done_ctrl` at `cycle_counter`=20 → `halted`=1, counter frozen at 21. 10 idle cycles → unchanged. `init_ctrl` → RUN, next fetch 0, counter resumes from 21.
- `FETCH_RAS_EN`, `RAS_DEPTH`=4: 5 nested calls from pc 10,20,30,40,50 → `ras_err`=1. 4 rets return 41,31,21,11. 5th ret → pc+1, `ras_err` stays 1.
- `CYC_W`=4: run 20 cycles → `cycle_counter` stops at 15. Assert `reset` mid-stall → all outputs 0 immediately.
